// File: rtl/holy_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// holy_plic_claim_ctrl
// Hardware claim/complete sequencer for holy_plic. When ext_irq_i is seen in
// IDLE, it reads the PLIC claim register over AXI-Lite. A non-zero ID is held
// on irq_valid_o/irq_id_o until the core signals irq_done_i. The same ID is
// then written back to the claim register as the completion.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ext_irq_i           level interrupt from holy_plic
//   irq_valid_o/id_o    claimed ID presented to the core
//   irq_done_i          core finished servicing (pulse or level)
//   bus_err_o           one-cycle pulse on a non-OKAY rresp/bresp
//   m_axi_*             AXI-Lite master (AR/R for claim, AW/W/B for complete)
//
// ID_W must be <= 32.
// ---------------------------------------------------------------------------
module holy_plic_claim_ctrl #(
    parameter logic [31:0] CLAIM_ADDR = 32'h0000_0004,
    parameter int unsigned ID_W       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ext_irq_i,
    output logic            irq_valid_o,
    output logic [ID_W-1:0] irq_id_o,
    input  logic            irq_done_i,
    output logic            bus_err_o,
    output logic [31:0]     m_axi_araddr,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [31:0]     m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready,
    output logic [31:0]     m_axi_awaddr,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [31:0]     m_axi_wdata,
    output logic [3:0]      m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_HOLD,
        S_WR,
        S_WR_B
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic            arvalid_nx;
    logic            rready_nx;
    logic            awvalid_nx;
    logic            wvalid_nx;
    logic            bready_nx;
    logic            irq_valid_nx;
    logic            bus_err_nx;
    logic [ID_W-1:0] id_nx;

    logic ar_hs;
    logic r_hs;
    logic b_hs;
    logic aw_done;
    logic w_done;

    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid  && m_axi_rready;
    assign b_hs  = m_axi_bvalid  && m_axi_bready;

    // In WR each valid rises on entry, so a low valid means that channel is done
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    // Fixed address/strobe; completion data is the latched ID zero-extended
    assign m_axi_araddr = CLAIM_ADDR;
    assign m_axi_awaddr = CLAIM_ADDR;
    assign m_axi_wstrb  = 4'hF;
    assign m_axi_wdata  = 32'(irq_id_o);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            irq_valid_o   <= 1'b0;
            irq_id_o      <= '0;
            bus_err_o     <= 1'b0;
        end else begin
            state_q       <= state_nx;
            m_axi_arvalid <= arvalid_nx;
            m_axi_rready  <= rready_nx;
            m_axi_awvalid <= awvalid_nx;
            m_axi_wvalid  <= wvalid_nx;
            m_axi_bready  <= bready_nx;
            irq_valid_o   <= irq_valid_nx;
            irq_id_o      <= id_nx;
            bus_err_o     <= bus_err_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE: if (ext_irq_i) state_nx = S_AR;
            S_AR:   if (ar_hs) state_nx = S_R;
            S_R: begin
                if (r_hs) begin
                    if (m_axi_rresp != RESP_OKAY || m_axi_rdata == 32'h0) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: if (irq_done_i) state_nx = S_WR;
            S_WR:   if (aw_done && w_done) state_nx = S_WR_B;
            S_WR_B: if (b_hs) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        arvalid_nx   = (state_nx == S_AR);
        rready_nx    = (state_nx == S_R);
        bready_nx    = (state_nx == S_WR_B);
        irq_valid_nx = (state_nx == S_HOLD);
        awvalid_nx   = (state_nx == S_WR) &&
                       ((state_q != S_WR) || (m_axi_awvalid && !m_axi_awready));
        wvalid_nx    = (state_nx == S_WR) &&
                       ((state_q != S_WR) || (m_axi_wvalid && !m_axi_wready));
        bus_err_nx   = ((state_q == S_R)    && r_hs && (m_axi_rresp != RESP_OKAY)) ||
                       ((state_q == S_WR_B) && b_hs && (m_axi_bresp != RESP_OKAY));
        id_nx        = irq_id_o;
        if (state_q == S_R && r_hs && m_axi_rresp == RESP_OKAY && m_axi_rdata != 32'h0) begin
            id_nx = m_axi_rdata[ID_W-1:0];
        end
    end

endmodule

// File: tb/tb_holy_plic_claim_ctrl.sv
module tb_holy_plic_claim_ctrl;

    localparam int unsigned ID_W = 5;

    logic            clk;
    logic            rst_n;
    logic            ext_irq_i;
    logic            irq_valid_o;
    logic [ID_W-1:0] irq_id_o;
    logic            irq_done_i;
    logic            bus_err_o;
    logic [31:0]     m_axi_araddr;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [31:0]     m_axi_awaddr;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [31:0]     m_axi_wdata;
    logic [3:0]      m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_ar = 0;
    int cnt_aw = 0;
    int cnt_w  = 0;
    int cnt_b  = 0;
    int ar0, aw0, w0, b0;

    holy_plic_claim_ctrl #(
        .CLAIM_ADDR (32'h0000_0004),
        .ID_W       (ID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_irq_i     (ext_irq_i),
        .irq_valid_o   (irq_valid_o),
        .irq_id_o      (irq_id_o),
        .irq_done_i    (irq_done_i),
        .bus_err_o     (bus_err_o),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake counters, sampled at the active edge
    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) cnt_ar = cnt_ar + 1;
        if (m_axi_awvalid && m_axi_awready) cnt_aw = cnt_aw + 1;
        if (m_axi_wvalid  && m_axi_wready)  cnt_w  = cnt_w + 1;
        if (m_axi_bvalid  && m_axi_bready)  cnt_b  = cnt_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        ar0 = cnt_ar;
        aw0 = cnt_aw;
        w0  = cnt_w;
        b0  = cnt_b;
    endtask

    initial begin
        rst_n = 1'b0; ext_irq_i = 1'b0; irq_done_i = 1'b0;
        m_axi_arready = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_irq_valid", 32'(irq_valid_o), 32'd0);
        chk("rst_irq_id",    32'(irq_id_o), 32'd0);
        chk("rst_arvalid",   32'(m_axi_arvalid), 32'd0);
        chk("rst_rready",    32'(m_axi_rready), 32'd0);
        chk("rst_awvalid",   32'(m_axi_awvalid), 32'd0);
        chk("rst_wvalid",    32'(m_axi_wvalid), 32'd0);
        chk("rst_bready",    32'(m_axi_bready), 32'd0);
        chk("rst_bus_err",   32'(bus_err_o), 32'd0);
        rst_n = 1'b1;

        // Zero-wait slave, claim returns 3
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h3;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
        ext_irq_i = 1'b1;
        tick();
        chk("s1_arvalid",  32'(m_axi_arvalid), 32'd1);
        chk("s1_araddr",   m_axi_araddr, 32'h4);
        chk("s1_valid_c1", 32'(irq_valid_o), 32'd0);
        ext_irq_i = 1'b0;
        tick();
        chk("s1_ar_drop",  32'(m_axi_arvalid), 32'd0);
        chk("s1_rready",   32'(m_axi_rready), 32'd1);
        chk("s1_valid_c2", 32'(irq_valid_o), 32'd0);
        tick();
        chk("s1_valid_c3", 32'(irq_valid_o), 32'd1);
        chk("s1_id",       32'(irq_id_o), 32'd3);
        chk("s1_rready_0", 32'(m_axi_rready), 32'd0);
        tick();
        chk("s1_valid_hold", 32'(irq_valid_o), 32'd1);
        chk("s1_id_hold",    32'(irq_id_o), 32'd3);
        chk("s1_no_aw",      32'(m_axi_awvalid), 32'd0);
        snap();
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        chk("s1_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("s1_wvalid",  32'(m_axi_wvalid), 32'd1);
        chk("s1_awaddr",  m_axi_awaddr, 32'h4);
        chk("s1_wdata",   m_axi_wdata, 32'h3);
        chk("s1_wstrb",   32'(m_axi_wstrb), 32'hF);
        chk("s1_valid_wr", 32'(irq_valid_o), 32'd0);
        tick();
        chk("s1_aw_drop", 32'(m_axi_awvalid), 32'd0);
        chk("s1_w_drop",  32'(m_axi_wvalid), 32'd0);
        chk("s1_bready",  32'(m_axi_bready), 32'd1);
        tick();
        chk("s1_bready_0", 32'(m_axi_bready), 32'd0);
        chk("s1_idle_ar",  32'(m_axi_arvalid), 32'd0);
        chk("s1_n_aw", 32'(cnt_aw - aw0), 32'd1);
        chk("s1_n_w",  32'(cnt_w - w0), 32'd1);
        chk("s1_n_b",  32'(cnt_b - b0), 32'd1);
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;

        // Delayed arready, wready two cycles ahead of awready
        ext_irq_i = 1'b1;
        tick();
        chk("s2_arvalid", 32'(m_axi_arvalid), 32'd1);
        ext_irq_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2_ar_stable", 32'(m_axi_arvalid), 32'd1);
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("s2_ar_drop", 32'(m_axi_arvalid), 32'd0);
        chk("s2_rready",  32'(m_axi_rready), 32'd1);
        tick();
        chk("s2_rready_wait", 32'(m_axi_rready), 32'd1);
        chk("s2_valid_wait",  32'(irq_valid_o), 32'd0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hA;
        tick();
        m_axi_rvalid = 1'b0;
        chk("s2_valid", 32'(irq_valid_o), 32'd1);
        chk("s2_id",    32'(irq_id_o), 32'd10);
        snap();
        irq_done_i = 1'b1; m_axi_wready = 1'b1;
        tick();
        irq_done_i = 1'b0;
        chk("s2_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("s2_wvalid",  32'(m_axi_wvalid), 32'd1);
        tick();
        m_axi_wready = 1'b0;
        chk("s2_w_drop",    32'(m_axi_wvalid), 32'd0);
        chk("s2_aw_hold1",  32'(m_axi_awvalid), 32'd1);
        tick();
        chk("s2_aw_hold2",  32'(m_axi_awvalid), 32'd1);
        chk("s2_w_stay0",   32'(m_axi_wvalid), 32'd0);
        chk("s2_no_bready", 32'(m_axi_bready), 32'd0);
        m_axi_awready = 1'b1;
        tick();
        m_axi_awready = 1'b0;
        chk("s2_aw_drop", 32'(m_axi_awvalid), 32'd0);
        chk("s2_bready",  32'(m_axi_bready), 32'd1);
        tick();
        chk("s2_bready_wait", 32'(m_axi_bready), 32'd1);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("s2_bready_0", 32'(m_axi_bready), 32'd0);
        tick();
        chk("s2_n_aw", 32'(cnt_aw - aw0), 32'd1);
        chk("s2_n_w",  32'(cnt_w - w0), 32'd1);
        chk("s2_n_b",  32'(cnt_b - b0), 32'd1);

        // Spurious claim (ID 0)
        snap();
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0;
        ext_irq_i = 1'b1;
        tick();
        ext_irq_i = 1'b0;
        tick();
        tick();
        chk("s3_valid",   32'(irq_valid_o), 32'd0);
        chk("s3_rready0", 32'(m_axi_rready), 32'd0);
        chk("s3_ar_idle", 32'(m_axi_arvalid), 32'd0);
        tick();
        chk("s3_valid2",  32'(irq_valid_o), 32'd0);
        chk("s3_no_aw",   32'(m_axi_awvalid), 32'd0);
        chk("s3_n_aw",    32'(cnt_aw - aw0), 32'd0);
        chk("s3_n_w",     32'(cnt_w - w0), 32'd0);

        // Read error response
        snap();
        m_axi_rresp = 2'b10; m_axi_rdata = 32'h7;
        ext_irq_i = 1'b1;
        tick();
        ext_irq_i = 1'b0;
        tick();
        tick();
        chk("s4_rerr_pulse", 32'(bus_err_o), 32'd1);
        chk("s4_rerr_valid", 32'(irq_valid_o), 32'd0);
        tick();
        chk("s4_rerr_end",   32'(bus_err_o), 32'd0);
        chk("s4_rerr_no_aw", 32'(m_axi_awvalid), 32'd0);
        chk("s4_rerr_n_aw",  32'(cnt_aw - aw0), 32'd0);

        // Write error response on completion
        m_axi_rresp = 2'b00; m_axi_rdata = 32'h2;
        ext_irq_i = 1'b1;
        tick();
        ext_irq_i = 1'b0;
        tick();
        tick();
        chk("s4_id", 32'(irq_id_o), 32'd2);
        irq_done_i = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        tick();
        irq_done_i = 1'b0;
        chk("s4_wdata", m_axi_wdata, 32'h2);
        tick();
        chk("s4_bready",   32'(m_axi_bready), 32'd1);
        chk("s4_err_pre",  32'(bus_err_o), 32'd0);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        tick();
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        chk("s4_berr_pulse", 32'(bus_err_o), 32'd1);
        chk("s4_berr_bready", 32'(m_axi_bready), 32'd0);
        tick();
        chk("s4_berr_end", 32'(bus_err_o), 32'd0);
        chk("s4_idle_ar",  32'(m_axi_arvalid), 32'd0);

        // ext_irq held high across completion, second claim returns 5
        m_axi_rdata = 32'h4;
        ext_irq_i = 1'b1;
        tick();
        tick();
        tick();
        chk("s5_id1", 32'(irq_id_o), 32'd4);
        snap();
        m_axi_rdata = 32'h5;
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        tick();
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("s5_idle_no_ar", 32'(m_axi_arvalid), 32'd0);
        chk("s5_idle_bready", 32'(m_axi_bready), 32'd0);
        tick();
        chk("s5_ar2", 32'(m_axi_arvalid), 32'd1);
        chk("s5_n_ar_pre", 32'(cnt_ar - ar0), 32'd0);
        tick();
        chk("s5_n_ar", 32'(cnt_ar - ar0), 32'd1);
        tick();
        chk("s5_valid2", 32'(irq_valid_o), 32'd1);
        chk("s5_id2",    32'(irq_id_o), 32'd5);
        ext_irq_i = 1'b0;

        // Reset during HOLD
        rst_n = 1'b0;
        tick();
        chk("s6_hold_valid", 32'(irq_valid_o), 32'd0);
        chk("s6_hold_id",    32'(irq_id_o), 32'd0);
        chk("s6_hold_ar",    32'(m_axi_arvalid), 32'd0);
        chk("s6_hold_rr",    32'(m_axi_rready), 32'd0);
        chk("s6_hold_err",   32'(bus_err_o), 32'd0);
        rst_n = 1'b1; ext_irq_i = 1'b1;
        tick();
        chk("s6_restart_ar", 32'(m_axi_arvalid), 32'd1);
        ext_irq_i = 1'b0;
        tick();
        tick();
        chk("s6_valid", 32'(irq_valid_o), 32'd1);

        // Reset during WR
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        chk("s6_wr_aw", 32'(m_axi_awvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("s6_wr_aw0",    32'(m_axi_awvalid), 32'd0);
        chk("s6_wr_w0",     32'(m_axi_wvalid), 32'd0);
        chk("s6_wr_b0",     32'(m_axi_bready), 32'd0);
        chk("s6_wr_valid0", 32'(irq_valid_o), 32'd0);
        chk("s6_wr_id0",    32'(irq_id_o), 32'd0);
        rst_n = 1'b1; ext_irq_i = 1'b1;
        tick();
        chk("s6_wr_restart", 32'(m_axi_arvalid), 32'd1);
        chk("s6_wr_araddr",  m_axi_araddr, 32'h4);
        ext_irq_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
